// File: rtl/rv32i_fetch_decode.sv
// RV32I fetch front end: PC, in-order imem fetch, instruction buffer and opcode pre-decode.
// Optional feature macro: RV32I_FETCH_MISALIGN_TRAP_EN. When it is defined, a misaligned redirect
// presents one trap entry and halts fetch. When it is not defined, redirect_pc[1:0] is forced to zero.
module rv32i_fetch_decode #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [24:0] id_instr31to7,
  output logic [2:0]  id_imm_sel,
  output logic        id_illegal,
  output logic        id_misalign
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   pc;
  logic [CW-1:0] occ, outs, outs_next, drop;
  logic [PW-1:0] f_rd, f_wr, p_rd, p_wr;
  logic [31:0]   fq_pc    [FIFO_DEPTH];
  logic [31:0]   fq_instr [FIFO_DEPTH];
  logic [31:0]   pq       [FIFO_DEPTH];  // PCs of in-flight requests, oldest first
  logic [31:0]   redir_pc, head_instr;
  logic          halted, mis_pend, head_mis;
  logic          req_fire, rsp_v, rsp_keep, mis_push, push_en, pop;
  logic [2:0]    dec_sel;
  logic          dec_ill;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Responses only count while something is in flight; stale pre-reset returns are ignored.
  assign rsp_v     = imem_rsp_valid && (outs != '0);
  assign rsp_keep  = rsp_v && (drop == '0);
  assign mis_push  = mis_pend && !redirect_valid;
  assign push_en   = !redirect_valid && (rsp_keep || mis_push);
  assign pop       = id_valid && id_ready;
  assign outs_next = outs + CW'(req_fire) - CW'(rsp_v);

  assign imem_req_valid = rst_n && !redirect_valid && !halted &&
                          (({1'b0, occ} + {1'b0, outs}) < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
  logic fq_mis [FIFO_DEPTH];
  assign redir_pc    = redirect_pc;
  assign head_mis    = fq_mis[f_rd];
  assign id_misalign = id_valid && head_mis;

  // Misaligned redirect: halt fetch, then queue a single trap entry the cycle after.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted   <= 1'b0;
      mis_pend <= 1'b0;
    end else if (redirect_valid) begin
      halted   <= |redirect_pc[1:0];
      mis_pend <= |redirect_pc[1:0];
    end else if (mis_pend) begin
      mis_pend <= 1'b0;
    end
  end

  // Trap marker travels with its buffer entry.
  always_ff @(posedge clk) begin
    if (push_en) fq_mis[f_wr] <= mis_push;
  end
`else
  assign redir_pc    = redirect_pc & 32'hFFFF_FFFC;
  assign halted      = 1'b0;
  assign mis_pend    = 1'b0;
  assign head_mis    = 1'b0;
  assign id_misalign = 1'b0;
`endif

  // Control state: PC, counters, pointers; redirect flushes the buffer and drops all in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      occ  <= '0;
      outs <= '0;
      drop <= '0;
      f_rd <= '0;
      f_wr <= '0;
      p_rd <= '0;
      p_wr <= '0;
    end else begin
      outs <= outs_next;
      if (req_fire) begin
        p_wr <= nxt(p_wr);
        pc   <= pc + 32'd4;
      end
      if (rsp_v) p_rd <= nxt(p_rd);
      if (redirect_valid) begin
        pc   <= redir_pc;
        drop <= outs_next;
        occ  <= '0;
        f_rd <= '0;
        f_wr <= '0;
      end else begin
        if (rsp_v && (drop != '0)) drop <= drop - CW'(1);
        if (push_en) f_wr <= nxt(f_wr);
        if (pop)     f_rd <= nxt(f_rd);
        occ <= occ + CW'(push_en) - CW'(pop);
      end
    end
  end

  // Storage: in-flight PC queue and instruction buffer payload (no reset needed, outputs gated).
  always_ff @(posedge clk) begin
    if (req_fire) pq[p_wr] <= pc;
    if (push_en) begin
      fq_pc[f_wr]    <= mis_push ? pc : pq[p_rd];
      fq_instr[f_wr] <= mis_push ? 32'd0 : imem_rsp_data;
    end
  end

  assign id_valid   = (occ != '0);
  assign head_instr = fq_instr[f_rd];

  // Opcode to immediate format; unknown opcodes flag illegal.
  always_comb begin
    dec_sel = 3'b000;
    dec_ill = 1'b0;
    case (head_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b0110011, 7'b0001111, 7'b1110011: dec_sel = 3'b000;
      7'b0100011:                         dec_sel = 3'b001;
      7'b1100011:                         dec_sel = 3'b010;
      7'b1101111:                         dec_sel = 3'b011;
      7'b0110111, 7'b0010111:             dec_sel = 3'b100;
      default: begin
        dec_sel = 3'b111;
        dec_ill = 1'b1;
      end
    endcase
  end

  assign id_pc         = id_valid ? fq_pc[f_rd] : 32'd0;
  assign id_instr31to7 = id_valid ? head_instr[31:7] : 25'd0;
  assign id_imm_sel    = (id_valid && !head_mis) ? dec_sel : 3'b000;
  assign id_illegal    = id_valid && !head_mis && dec_ill;
endmodule

// File: tb/tb_rv32i_fetch_decode.sv
// Scoreboard bench for rv32i_fetch_decode: directed stimulus queues expected decode
// entries, a monitor pops and compares on every id handshake.
`timescale 1ns/1ps
module tb_rv32i_fetch_decode;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [24:0] id_instr31to7;
  logic [2:0]  id_imm_sel;
  logic        id_illegal, id_misalign;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  rv32i_fetch_decode #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr31to7(id_instr31to7),
    .id_imm_sel(id_imm_sel), .id_illegal(id_illegal), .id_misalign(id_misalign)
  );

  typedef struct {logic [31:0] pc; logic [24:0] ins; logic [2:0] sel; logic ill; logic mis;} exp_t;
  typedef struct {logic [31:0] addr; int due;} fl_t;
  exp_t        sbq[$];
  fl_t         fl[$];
  logic [31:0] req_log[$];
  logic [31:0] mem [logic [31:0]];
  int          lat = 1, mcyc = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] w, input logic [2:0] sel,
                          input logic ill, input logic mis);
    exp_t e;
    e.pc = pc; e.ins = w[31:7]; e.sel = sel; e.ill = ill; e.mis = mis;
    sbq.push_back(e);
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [31:0] exp);
    if (req_log.size() <= idx) begin
      checks++; errors++;
      $display("FAIL %s: only %0d requests logged, expected address %h", nm, req_log.size(), exp);
    end else chk(nm, req_log[idx], exp);
  endtask

  // Memory model: fixed latency, in-order responses, one per cycle, driven between edges.
  always @(negedge clk) begin
    fl_t f;
    #1;
    mcyc++;
    imem_rsp_valid = 1'b0;
    if (!rst_n) fl.delete();
    else begin
      if (fl.size() > 0 && fl[0].due <= mcyc) begin
        f = fl.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_at(f.addr);
      end
      if (imem_req_valid && imem_req_ready) begin
        f.addr = imem_req_addr; f.due = mcyc + lat;
        fl.push_back(f);
        req_log.push_back(imem_req_addr);
      end
    end
  end

  // Monitor: every decode handshake must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && id_valid && id_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_id: got pc %h instr %h, expected no instruction", id_pc, id_instr31to7);
      end else begin
        e = sbq.pop_front();
        if (id_pc !== e.pc || id_instr31to7 !== e.ins || id_imm_sel !== e.sel ||
            id_illegal !== e.ill || id_misalign !== e.mis) begin
          errors++;
          $display("FAIL id_entry: got pc %h ins %h sel %b ill %b mis %b expected pc %h ins %h sel %b ill %b mis %b",
                   id_pc, id_instr31to7, id_imm_sel, id_illegal, id_misalign,
                   e.pc, e.ins, e.sel, e.ill, e.mis);
        end
      end
    end
  end

  task automatic drain(input string nm);
    int n = 0;
    id_ready = 1'b1;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    id_ready = 1'b0;
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d entries never presented, expected 0 left", nm, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic redirect(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    req_log.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h0]   = 32'h0050_0093;
    mem[32'h4]   = 32'h0010_2023;
    mem[32'h100] = 32'h00A0_0113;
    mem[32'h200] = 32'hFE00_0EE3;
    mem[32'h204] = 32'h0080_006F;
    mem[32'h208] = 32'h1234_52B7;
    mem[32'h20C] = 32'h0000_007F;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_illegal", {31'd0, id_illegal}, 32'd0);
    chk("rst_misalign", {31'd0, id_misalign}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_instr", {7'd0, id_instr31to7}, 32'd0);
    chk("rst_imm_sel", {29'd0, id_imm_sel}, 32'd0);

    // Basic fetch with 1-cycle memory and a stalled decode
    rst_n = 1'b1;
    #2;
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'd0);
    @(negedge clk);
    chk("latency_not_yet", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    chk("latency_valid", {31'd0, id_valid}, 32'd1);
    repeat (4) @(negedge clk);
    chk("stall_req_count", req_log.size(), 32'd2);
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold_pc", id_pc, 32'd0);
      chk("stall_hold_instr", {7'd0, id_instr31to7}, 32'h0000_A001);
      chk("stall_hold_sel", {29'd0, id_imm_sel}, 32'd0);
      @(negedge clk);
    end
    push_exp(32'h0, 32'h0050_0093, 3'b000, 1'b0, 1'b0);
    push_exp(32'h4, 32'h0010_2023, 3'b001, 1'b0, 1'b0);
    drain("basic");

    // Opcode decode after a redirect that flushes a full buffer
    redirect(32'h200);
    push_exp(32'h200, 32'hFE00_0EE3, 3'b010, 1'b0, 1'b0);
    push_exp(32'h204, 32'h0080_006F, 3'b011, 1'b0, 1'b0);
    push_exp(32'h208, 32'h1234_52B7, 3'b100, 1'b0, 1'b0);
    push_exp(32'h20C, 32'h0000_007F, 3'b111, 1'b1, 1'b0);
    drain("opcodes");

    // 3-cycle memory, two in flight, redirect drops both
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    lat = 3;
    req_log.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("lat3_outstanding", req_log.size(), 32'd2);
    redirect(32'h100);
    push_exp(32'h100, 32'h00A0_0113, 3'b000, 1'b0, 1'b0);
    drain("drop");
    chk_log("drop_first_addr", 0, 32'h100);

    // PC wrap
    lat = 1;
    redirect(32'hFFFF_FFFC);
    repeat (5) @(negedge clk);
    chk_log("wrap_addr0", 0, 32'hFFFF_FFFC);
    chk_log("wrap_addr1", 1, 32'h0000_0000);
    push_exp(32'hFFFF_FFFC, 32'h0000_0013, 3'b000, 1'b0, 1'b0);
    push_exp(32'h0, 32'h0050_0093, 3'b000, 1'b0, 1'b0);
    drain("wrap");

    // Misaligned redirect
    redirect(32'h102);
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    repeat (5) @(negedge clk);
    chk("mis_no_req", req_log.size(), 32'd0);
    push_exp(32'h102, 32'd0, 3'b000, 1'b0, 1'b1);
    drain("misalign");
    repeat (5) @(negedge clk);
    chk("mis_halt_req", req_log.size(), 32'd0);
    chk("mis_halt_valid", {31'd0, id_valid}, 32'd0);
    redirect(32'h300);
    push_exp(32'h300, 32'h0000_0013, 3'b000, 1'b0, 1'b0);
    drain("resume");
`else
    push_exp(32'h100, 32'h00A0_0113, 3'b000, 1'b0, 1'b0);
    drain("force_align");
    chk_log("force_align_addr", 0, 32'h100);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
